// File: rtl/fir_pkg.sv
// Shared constants for the 8-tap symmetric low-pass FIR.
// The Q1.15 coefficients sum to 32768, which is unity DC gain.
package fir_pkg;

    localparam int unsigned TAPS   = 8;
    localparam int unsigned COEFFW = 16;
    localparam int unsigned ACC_W  = 35;
    localparam int          ROUND  = 1 << 14;
    localparam int unsigned SHIFT  = 15;

    typedef logic signed [COEFFW-1:0] coeff_t;

    localparam coeff_t COEFFS [TAPS] = '{
        16'sd1024, 16'sd2048, 16'sd4096, 16'sd9216,
        16'sd9216, 16'sd4096, 16'sd2048, 16'sd1024
    };

    function automatic longint sat_max(input int unsigned n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int unsigned n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(16);
    localparam longint SAT_MIN = sat_min(16);

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate over the delay line, followed by
// round-half-up, arithmetic shift and saturation back to N bits.
module fir_mac
    import fir_pkg::*;
#(
    parameter int unsigned N                = 16,
    parameter coeff_t      COEFFS_P [TAPS]  = COEFFS
) (
    input  logic signed [N-1:0] taps_i [TAPS],
    output logic signed [N-1:0] y_o
);

    localparam int unsigned AccW = 2 * N + 3;
    localparam logic signed [AccW-1:0] YMax = AccW'(sat_max(N));
    localparam logic signed [AccW-1:0] YMin = AccW'(sat_min(N));

    logic signed [AccW-1:0] acc;
    logic signed [AccW-1:0] rnd;

    always_comb begin
        logic signed [AccW-1:0] xe;
        logic signed [AccW-1:0] ce;
        acc = '0;
        xe  = '0;
        ce  = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            xe  = {{(AccW - N){taps_i[i][N-1]}}, taps_i[i]};
            ce  = {{(AccW - COEFFW){COEFFS_P[i][COEFFW-1]}}, COEFFS_P[i]};
            acc = acc + xe * ce;
        end
    end

    assign rnd = (acc + AccW'(ROUND)) >>> SHIFT;

    always_comb begin
        if (rnd > YMax) begin
            y_o = YMax[N-1:0];
        end else if (rnd < YMin) begin
            y_o = YMin[N-1:0];
        end else begin
            y_o = rnd[N-1:0];
        end
    end

endmodule

// File: rtl/fir_filter.sv
// Fixed-coefficient 8-tap FIR: delay line plus registered output, one sample per clock.
// data_out reflects the delay line as it stood before the current edge's shift.
module fir_filter
    import fir_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [N-1:0] data_in,
    output logic signed [N-1:0] data_out
);

    logic signed [N-1:0] taps_q [TAPS];
    logic signed [N-1:0] y_d;

    fir_mac #(
        .N        (N),
        .COEFFS_P (COEFFS)
    ) u_mac (
        .taps_i (taps_q),
        .y_o    (y_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                taps_q[i] <= '0;
            end
            data_out <= '0;
        end else begin
            taps_q[0] <= data_in;
            for (int unsigned i = 1; i < TAPS; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
            data_out <= y_d;
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed impulse/step/extreme/rounding cases
// plus randomized and sine streams checked against a sample-history reference model.
module tb_fir_filter;

    logic               clk;
    logic               reset;
    logic signed [15:0] data_in;
    logic signed [15:0] data_out;

    int n_checks;
    int n_errors;

    // Most recent sample first; cleared whenever reset is asserted.
    longint hist [8];
    longint h    [8] = '{1024, 2048, 4096, 9216, 9216, 4096, 2048, 1024};

    fir_filter #(
        .N (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_y();
        longint acc;
        longint y;
        acc = 0;
        for (int i = 0; i < 8; i++) acc += h[i] * hist[i];
        y = (acc + 16384) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) hist[i] = 0;
    endfunction

    // Present one sample at the negedge, clock it in, and compare against the model.
    task automatic drive(input logic signed [15:0] v, input string tag);
        longint exp;
        data_in = v;
        @(posedge clk);
        exp = model_y();
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'(v);
        @(negedge clk);
        check_eq(tag, longint'(data_out), exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_hold", longint'(data_out), 0);
        reset = 1'b0;
    endtask

    longint imp_exp  [9] = '{512, 1024, 2048, 4608, 4608, 2048, 1024, 512, 0};
    longint step_exp [8] = '{512, 1536, 3584, 8192, 12800, 14848, 15872, 16384};
    logic signed [15:0] sine [32];

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        data_in = '0;
        reset   = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sine[i] = 16'($rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * i / 32.0) + 0.5)));
        end
        do_reset();

        // Impulse of 16384: first edge only loads x0, then the coefficient shape emerges.
        drive(16'sd16384, "imp_load");
        check_eq("imp_first", longint'(data_out), 0);
        for (int i = 0; i < 9; i++) begin
            drive(16'sd0, "imp_model");
            check_eq($sformatf("imp_%0d", i), longint'(data_out), imp_exp[i]);
        end

        do_reset();
        drive(16'sd16384, "step_load");
        for (int i = 0; i < 8; i++) begin
            drive(16'sd16384, "step_model");
            check_eq($sformatf("step_%0d", i), longint'(data_out), step_exp[i]);
        end
        drive(16'sd16384, "step_steady");
        check_eq("step_steady_val", longint'(data_out), 16384);

        // Full-scale holds must settle exactly on the rails without wrapping.
        for (int i = 0; i < 10; i++) drive(16'sd32767, "max_model");
        check_eq("max_steady", longint'(data_out), 32767);
        for (int i = 0; i < 10; i++) drive(-16'sd32768, "min_model");
        check_eq("min_steady", longint'(data_out), -32768);
        for (int i = 0; i < 10; i++) drive(16'sd32767, "swing_model");
        check_eq("swing_steady", longint'(data_out), 32767);

        do_reset();
        drive(16'sd1, "rnd1_load");
        for (int i = 0; i < 8; i++) begin
            drive(16'sd0, "rnd1_model");
            check_eq($sformatf("rnd1_%0d", i), longint'(data_out), 0);
        end
        drive(16'sd4, "rnd4_load");
        drive(16'sd0, "rnd4_h0");
        check_eq("rnd4_h0_val", longint'(data_out), 0);
        drive(16'sd0, "rnd4_h1");
        drive(16'sd0, "rnd4_h2");
        check_eq("rnd4_h2_val", longint'(data_out), 1);
        drive(16'sd0, "rnd4_h3");
        check_eq("rnd4_h3_val", longint'(data_out), 1);

        // Random stream mixing arbitrary values with both rails.
        for (int i = 0; i < 300; i++) begin
            logic signed [15:0] r;
            case ($urandom_range(0, 7))
                0:       r = 16'sd32767;
                1:       r = -16'sd32768;
                default: r = 16'($urandom);
            endcase
            drive(r, "rand");
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_eq("async_reset", longint'(data_out), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(16'sd16384, "post_rst_load");
        check_eq("post_rst_first", longint'(data_out), 0);
        drive(16'sd0, "post_rst_model");
        check_eq("post_rst_h0", longint'(data_out), 512);
        drive(16'sd0, "post_rst_model2");
        check_eq("post_rst_h1", longint'(data_out), 1024);

        // Cyclic full-scale sine: every output compared to the model across table wraps.
        for (int i = 0; i < 32 * 4; i++) drive(sine[i % 32], "sine");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
